// File: rtl/round_sgf_apply_pkg.sv
// Shared FPU format constants for the rounding-apply stage.
// Single and double precision widths plus the exponent all-ones helper.
package round_sgf_apply_pkg;

    localparam int SGL_SW = 23;
    localparam int SGL_EW = 8;
    localparam int DBL_SW = 52;
    localparam int DBL_EW = 11;

    // Biased exponent value reserved for Inf/NaN at a given exponent width.
    function automatic logic [63:0] exp_all_ones(input int ew);
        return (64'd1 << ew) - 64'd1;
    endfunction

endpackage

// File: rtl/round_sgf_apply_if.sv
// Operand/result handshake bundle for round_sgf_apply.
// slave is the rounding block, master is whoever feeds and drains it.
interface round_sgf_apply_if
    import round_sgf_apply_pkg::*;
#(
    parameter int SW = SGL_SW,
    parameter int EW = SGL_EW
);

    logic          in_valid_i;
    logic          in_ready_o;
    logic [SW-1:0] Sgf_i;
    logic [EW-1:0] Exp_i;
    logic          Sign_i;
    logic          Round_Flag_i;

    logic          out_valid_o;
    logic          out_ready_i;
    logic [SW-1:0] Sgf_o;
    logic [EW-1:0] Exp_o;
    logic          Sign_o;
    logic          Overflow_o;

    modport slave (
        input  in_valid_i, Sgf_i, Exp_i, Sign_i, Round_Flag_i, out_ready_i,
        output in_ready_o, out_valid_o, Sgf_o, Exp_o, Sign_o, Overflow_o
    );

    modport master (
        output in_valid_i, Sgf_i, Exp_i, Sign_i, Round_Flag_i, out_ready_i,
        input  in_ready_o, out_valid_o, Sgf_o, Exp_o, Sign_o, Overflow_o
    );

endinterface

// File: rtl/round_sgf_apply_inc.sv
// Parameterised W-bit conditional incrementer used for the rounding step.
module round_sgf_inc #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic         inc,
    output logic [W-1:0] sum
);

    assign sum = a + {{(W-1){1'b0}}, inc};

endmodule

// File: rtl/round_sgf_apply.sv
// Two-stage round-apply pipeline: S1 increments the fraction, S2 renormalises
// on carry, flags overflow to infinity and presents the registered result.
module round_sgf_apply
    import round_sgf_apply_pkg::*;
#(
    parameter int SW = SGL_SW,
    parameter int EW = SGL_EW
) (
    input logic              clk,
    input logic              rst,
    round_sgf_apply_if.slave bus
);

    localparam logic [EW-1:0] EXP_ONES = EW'(exp_all_ones(EW));

    typedef struct packed {
        logic [SW:0]   sum;
        logic [EW-1:0] exp;
        logic          sign;
        logic          special;
    } s1_t;

    logic          s1_valid;
    s1_t           s1;
    logic          s2_valid;
    logic [SW-1:0] s2_sgf;
    logic [EW-1:0] s2_exp;
    logic          s2_sign;
    logic          s2_ovf;

    logic          adv2;
    logic          in_ready;
    logic          accept;
    logic          in_special;
    logic [SW:0]   inc_sum;

    logic          carry;
    logic [EW-1:0] exp_adj;
    logic [SW-1:0] nxt_sgf;
    logic          nxt_ovf;

    assign adv2     = ~s2_valid | bus.out_ready_i;
    assign in_ready = ~s1_valid | adv2;
    assign accept   = bus.in_valid_i & in_ready;

    // Inf/NaN operands pass through unrounded.
    assign in_special = (bus.Exp_i == EXP_ONES);

    round_sgf_inc #(.W(SW + 1)) u_inc (
        .a   ({1'b0, bus.Sgf_i}),
        .inc (bus.Round_Flag_i & ~in_special),
        .sum (inc_sum)
    );

    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    always_comb begin
        carry   = s1.sum[SW];
        exp_adj = s1.exp + {{(EW-1){1'b0}}, carry};
        nxt_sgf = carry ? '0 : s1.sum[SW-1:0];
        nxt_ovf = 1'b0;
        if (!s1.special && exp_adj == EXP_ONES) begin
            nxt_ovf = 1'b1;
            nxt_sgf = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_sgf   <= '0;
            s2_exp   <= '0;
            s2_sign  <= 1'b0;
            s2_ovf   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid_i;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sgf  <= nxt_sgf;
                    s2_exp  <= exp_adj;
                    s2_sign <= s1.sign;
                    s2_ovf  <= nxt_ovf;
                end
            end
        end
    end

    // NOTE: the S1 payload is not reset; it is only ever observed qualified by s1_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1.sum     <= inc_sum;
            s1.exp     <= bus.Exp_i;
            s1.sign    <= bus.Sign_i;
            s1.special <= in_special;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = s2_valid;
    assign bus.Sgf_o       = s2_sgf;
    assign bus.Exp_o       = s2_exp;
    assign bus.Sign_o      = s2_sign;
    assign bus.Overflow_o  = s2_ovf;

endmodule

// File: tb/tb_round_sgf_apply.sv
// Scoreboard bench for round_sgf_apply: the driver queues hand-computed results
// on each accepted operand, a negedge monitor pops and compares on each output.
module tb_round_sgf_apply;
    import round_sgf_apply_pkg::*;

    localparam int SW = SGL_SW;
    localparam int EW = SGL_EW;

    typedef struct {
        logic [SW-1:0] sgf;
        logic [EW-1:0] exp;
        logic          sign;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    round_sgf_apply_if #(.SW(SW), .EW(EW)) bus ();

    round_sgf_apply #(.SW(SW), .EW(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   emit_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic          hold_pending = 1'b0;
    logic [SW-1:0] h_sgf;
    logic [EW-1:0] h_exp;
    logic          h_sign;
    logic          h_ovf;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: stability while stalled, and in-order comparison on every transfer.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(bus.out_valid_o), 64'd1);
                check("hold_sgf",   64'(bus.Sgf_o),       64'(h_sgf));
                check("hold_exp",   64'(bus.Exp_o),       64'(h_exp));
                check("hold_sign",  64'(bus.Sign_o),      64'(h_sign));
                check("hold_ovf",   64'(bus.Overflow_o),  64'(h_ovf));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                emit_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got sgf=%0h exp=%0h, required no output", bus.Sgf_o, bus.Exp_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_sgf",  64'(bus.Sgf_o),      64'(mon_e.sgf));
                    check("res_exp",  64'(bus.Exp_o),      64'(mon_e.exp));
                    check("res_sign", 64'(bus.Sign_o),     64'(mon_e.sign));
                    check("res_ovf",  64'(bus.Overflow_o), 64'(mon_e.ovf));
                end
            end
            hold_pending = bus.out_valid_o & ~bus.out_ready_i;
            h_sgf  = bus.Sgf_o;
            h_exp  = bus.Exp_o;
            h_sign = bus.Sign_o;
            h_ovf  = bus.Overflow_o;
        end
    end

    // Offer one operand and keep it up until accepted; leaves in_valid_i high.
    task automatic send(input logic [SW-1:0] s, input logic [EW-1:0] e, input logic sg,
                        input logic f, input logic [SW-1:0] xs, input logic [EW-1:0] xe,
                        input logic xo);
        bit done;
        int w;
        exp_t x;
        done = 1'b0;
        w = 0;
        bus.in_valid_i   = 1'b1;
        bus.Sgf_i        = s;
        bus.Exp_i        = e;
        bus.Sign_i       = sg;
        bus.Round_Flag_i = f;
        x.sgf  = xs;
        x.exp  = xe;
        x.sign = sg;
        x.ovf  = xo;
        while (!done && w < 50) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                exp_q.push_back(x);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            w++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no in_ready_o in %0d cycles, required acceptance", w);
            bus.in_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || bus.out_valid_o) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [SW-1:0] bs;
        logic [EW-1:0] be;
        logic          bf;

        bus.in_valid_i   = 1'b0;
        bus.out_ready_i  = 1'b0;
        bus.Sgf_i        = '0;
        bus.Exp_i        = '0;
        bus.Sign_i       = 1'b0;
        bus.Round_Flag_i = 1'b0;

        // Reset state, during and directly after reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_ovf",       64'(bus.Overflow_o),  64'd0);
        check("rst_sgf",       64'(bus.Sgf_o),       64'd0);
        check("rst_exp",       64'(bus.Exp_o),       64'd0);
        check("rst_sign",      64'(bus.Sign_o),      64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Minimum latency: result appears exactly two cycles after the handshake.
        bus.out_ready_i = 1'b1;
        send(23'h000001, 8'h80, 1'b0, 1'b1, 23'h000002, 8'h80, 1'b0);
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("lat_early", 64'(bus.out_valid_o), 64'd0);
        @(negedge clk);
        check("lat_two", 64'(bus.out_valid_o), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Carry, overflow, Inf/NaN passthrough and plain cases, back to back.
        send(23'h7FFFFF, 8'h7F, 1'b1, 1'b1, 23'h000000, 8'h80, 1'b0);
        send(23'h7FFFFF, 8'hFE, 1'b0, 1'b1, 23'h000000, 8'hFF, 1'b1);
        send(23'h123456, 8'h40, 1'b1, 1'b0, 23'h123456, 8'h40, 1'b0);
        send(23'h7FFFFF, 8'hFF, 1'b0, 1'b1, 23'h7FFFFF, 8'hFF, 1'b0);
        send(23'h000000, 8'hFF, 1'b1, 1'b1, 23'h000000, 8'hFF, 1'b0);
        send(23'h7FFFFE, 8'hFE, 1'b0, 1'b1, 23'h7FFFFF, 8'hFE, 1'b0);
        send(23'h7FFFFF, 8'hFE, 1'b1, 1'b0, 23'h7FFFFF, 8'hFE, 1'b0);
        send(23'h3FFFFF, 8'h01, 1'b0, 1'b1, 23'h400000, 8'h01, 1'b0);
        bus.in_valid_i = 1'b0;
        drain();

        // Backpressure: two accepted, third refused, then all three in order.
        bus.out_ready_i = 1'b0;
        send(23'h0000AA, 8'h10, 1'b0, 1'b1, 23'h0000AB, 8'h10, 1'b0);
        send(23'h0000BB, 8'h20, 1'b1, 1'b0, 23'h0000BB, 8'h20, 1'b0);
        bus.in_valid_i   = 1'b1;
        bus.Sgf_i        = 23'h0000CC;
        bus.Exp_i        = 8'h30;
        bus.Sign_i       = 1'b0;
        bus.Round_Flag_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready",  64'(bus.in_ready_o),  64'd0);
            check("stall_out_valid", 64'(bus.out_valid_o), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.out_ready_i = 1'b1;
        send(23'h0000CC, 8'h30, 1'b0, 1'b1, 23'h0000CD, 8'h30, 1'b0);
        bus.in_valid_i = 1'b0;
        drain();

        // Throughput: ten operands back to back emerge on ten consecutive cycles.
        emit_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            bs = SW'(i);
            be = EW'(8'h10 + i);
            bf = bs[0];
            send(bs, be, bf, bf, bs + {{(SW-1){1'b0}}, bf}, be, 1'b0);
        end
        bus.in_valid_i = 1'b0;
        drain();
        check("burst_count", 64'(emit_cyc.size()), 64'd10);
        for (int i = 1; i < emit_cyc.size(); i++) begin
            check("burst_gap", 64'(emit_cyc[i] - emit_cyc[i-1]), 64'd1);
        end

        // Reset with both stages full discards everything in flight.
        bus.out_ready_i = 1'b0;
        send(23'h7FFFFF, 8'h7F, 1'b1, 1'b1, 23'h000000, 8'h80, 1'b0);
        send(23'h000123, 8'h55, 1'b1, 1'b1, 23'h000124, 8'h55, 1'b0);
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready_o),  64'd1);
        check("mid_rst_sgf",       64'(bus.Sgf_o),       64'd0);
        check("mid_rst_exp",       64'(bus.Exp_o),       64'd0);
        check("mid_rst_sign",      64'(bus.Sign_o),      64'd0);
        check("mid_rst_ovf",       64'(bus.Overflow_o),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", 64'(bus.out_valid_o), 64'd0);
        end

        // Pipeline still works after the mid-run reset.
        @(posedge clk);
        #1;
        send(23'h000010, 8'h90, 1'b1, 1'b1, 23'h000011, 8'h90, 1'b0);
        bus.in_valid_i = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/round_sgf_apply.md
ROUND_SGF_APPLY -- requirements
Module: round_sgf_apply

Interface
REQ-001 SHALL have parameter SW, default 23, significand fraction width in bits.
REQ-002 SHALL have parameter EW, default 8, exponent width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  upstream operand valid.
REQ-006 SHALL have port in_ready_o  output  1  block can accept an operand this cycle.
REQ-007 SHALL have port Sgf_i  input  SW  truncated fraction to be rounded.
REQ-008 SHALL have port Exp_i  input  EW  biased exponent.
REQ-009 SHALL have port Sign_i  input  1  result sign.
REQ-010 SHALL have port Round_Flag_i  input  1  increment request from the round-decision logic, sampled with the operand.
REQ-011 SHALL have port out_valid_o  output  1  rounded result valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts the result.
REQ-013 SHALL have port Sgf_o  output  SW  rounded fraction.
REQ-014 SHALL have port Exp_o  output  EW  adjusted exponent.
REQ-015 SHALL have port Sign_o  output  1  sign, passed through unchanged.
REQ-016 SHALL have port Overflow_o  output  1  rounding overflowed to infinity; valid with out_valid_o.

Function
REQ-017 SHALL be a two-stage pipeline, S1 (increment) and S2 (renormalise/output), each holding one valid bit plus data.
REQ-018 SHALL complete a transfer on any side only when valid and ready are both high in the same cycle.
REQ-019 SHALL advance S2 when S2 is empty or out_ready_i is 1 (adv2).
REQ-020 SHALL drive in_ready_o = ~S1_valid | adv2, combinationally.
REQ-021 SHALL move S1 into S2 when S1_valid and adv2 are both 1.
REQ-022 SHALL clear S2_valid when out_ready_i is 1 and S1 holds no operand.
REQ-023 SHALL, in S1, compute an SW+1-bit sum = {0,Sgf_i} + Round_Flag_i on capture and register it with Exp_i, Sign_i.
REQ-024 SHALL, in S2, on carry (sum[SW]=1), output Sgf_o = 0 and Exp_o = Exp+1; otherwise output Sgf_o = sum[SW-1:0] and Exp_o = Exp.
REQ-025 SHALL set Overflow_o = 1 and Sgf_o = 0 when the adjusted exponent equals all ones; Exp_o is then all ones.
REQ-026 SHALL pass operands with Exp_i = all ones (Inf/NaN) unrounded: the increment is suppressed, and Overflow_o = 0.
REQ-027 SHALL have a minimum latency of 2 cycles, from in_valid_i&in_ready_o to out_valid_o.
REQ-028 SHALL sustain a throughput of one result per cycle while out_ready_i stays 1.
REQ-029 SHALL hold out_valid_o and all output data stable while out_valid_o=1 and out_ready_i=0.
REQ-030 SHALL preserve order: no operand lost, none duplicated.
REQ-031 SHALL, on simultaneous S2 drain and S1 refill in one cycle, accept, move and emit without a bubble.

Reset
REQ-032 SHALL clear S1_valid and S2_valid on rst=1 at a clock edge, including mid-operation; in-flight operands are discarded.
REQ-033 SHALL drive out_valid_o=0, Overflow_o=0, Sgf_o=0, Exp_o=0 and Sign_o=0 during and after reset.
REQ-034 SHALL drive in_ready_o=1 in the first cycle after reset.

Structure
REQ-035 SHALL take SW, EW and the exponent all-ones constant from the shared FPU package, with single (23/8) and double (52/11) variants.
REQ-036 SHALL instantiate one sub-module, round_sgf_inc, a parameterised SW+1-bit incrementer.

Verification
REQ-037 SHALL be verified by this case: Sgf_i=0x000001, Exp_i=0x80, Round_Flag_i=1, out_ready_i=1 -> two cycles later Sgf_o=0x000002, Exp_o=0x80, Overflow_o=0.
REQ-038 SHALL be verified by this case: Sgf_i=0x7FFFFF, Exp_i=0x7F, flag=1 -> Sgf_o=0x000000, Exp_o=0x80.
REQ-039 SHALL be verified by this case: Sgf_i=0x7FFFFF, Exp_i=0xFE, flag=1 -> Sgf_o=0, Exp_o=0xFF, Overflow_o=1.
REQ-040 SHALL be verified by this case: out_ready_i=0 while three operands are offered -> only two accepted, in_ready_o=0 on the third, outputs stable; after release all three emerge in order.
REQ-041 SHALL be verified by this case: continuous valid with out_ready_i=1 for 10 operands -> 10 results on 10 consecutive cycles.
REQ-042 SHALL be verified by this case: rst asserted with both stages full -> next cycle out_valid_o=0, in_ready_o=1, no stale result emitted.
